// File: rtl/nios2_dbg_pkg.sv
// Shared types and constants for the Nios II debug slave, system-clock side.
//   dbg_cmd_t : one queued debug command, the virtual IR plus the captured shift register
//   clog2     : ceiling log2, usable in constant expressions
package nios2_dbg_pkg;

  localparam int SR_W    = 38;
  localparam int IR_W    = 2;
  localparam int ACT_BIT = 34;
  localparam int NCH     = 1 << IR_W;

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] sr;
  } dbg_cmd_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/nios2_dbg_cmd_fifo.sv
// Synchronous command queue of dbg_cmd_t.
//   clk, reset  : system clock, async active-high reset (pointers and level only)
//   push        : enqueue push_data; refused when full unless a pop happens in the same cycle
//   pop         : dequeue the head; ignored when empty
//   head        : current head entry (valid when !empty)
//   full, empty : occupancy flags
//   level       : number of queued entries, 0..DEPTH
module nios2_dbg_cmd_fifo
  import nios2_dbg_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = clog2(DEPTH),
  localparam int LVL_W = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  dbg_cmd_t         push_data,
  input  logic             pop,
  output dbg_cmd_t         head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  dbg_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop & ~empty;
  // When full, a same-cycle pop frees the slot the push lands in (wr_ptr == rd_ptr),
  // and the head is read before the write takes effect.
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/nios2_dbg_slave_sysclk_mc.sv
// System-clock half of the multi-channel Nios II JTAG debug slave.
// Synchronises the TCK-domain update-IR/update-DR levels, latches the IR, queues
// {ir, sr} commands and issues one strobe per command to the addressed channel.
//   clk, reset      : system clock, async active-high reset
//   ir_in, sr       : TCK-domain IR and shift register (quasi-static around updates)
//   vs_uir, vs_udr  : TCK-domain update-IR / update-DR levels (asynchronous)
//   ch_ready        : per-channel consumer ready; the queue head waits for its channel
//   ovf_clr         : clears the sticky overflow flag
//   jdo             : sr of the most recently issued command
//   take_action     : one-cycle strobe on the head channel when sr[ACT_BIT] is 1
//   take_no_action  : one-cycle strobe on the head channel when sr[ACT_BIT] is 0
//   fifo_level      : queued command count
//   overflow        : sticky, set when an update-DR found the queue full
module nios2_dbg_slave_sysclk_mc
  import nios2_dbg_pkg::*;
#(
  parameter int  SYNC_STAGES = 2,
  parameter int  FIFO_DEPTH  = 4,
  localparam int LVL_W       = clog2(FIFO_DEPTH) + 1,
  localparam int ST_W        = clog2(SYNC_STAGES + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IR_W-1:0]  ir_in,
  input  logic [SR_W-1:0]  sr,
  input  logic             vs_uir,
  input  logic             vs_udr,
  input  logic [NCH-1:0]   ch_ready,
  input  logic             ovf_clr,
  output logic [SR_W-1:0]  jdo,
  output logic [NCH-1:0]   take_action,
  output logic [NCH-1:0]   take_no_action,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow
);

  logic [SYNC_STAGES-1:0] uir_sync;
  logic [SYNC_STAGES-1:0] udr_sync;
  logic                   uir_hist;
  logic                   udr_hist;
  logic                   uir_armed;
  logic                   udr_armed;
  logic [ST_W-1:0]        settle_cnt;
  logic                   settle_done;
  logic                   ev_uir;
  logic                   ev_udr;
  logic [IR_W-1:0]        ir_lat;

  dbg_cmd_t               push_data;
  dbg_cmd_t               head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic [NCH-1:0]         head_onehot;

  // After reset the synchronisers start at 0, so a level that was held high through
  // reset would look like a fresh rising edge. An edge detector is only armed once the
  // chain has flushed (settle_cnt reaches 0) and the synchronised level has been seen low.
  assign settle_done = (settle_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uir_sync   <= '0;
      udr_sync   <= '0;
      uir_hist   <= 1'b0;
      udr_hist   <= 1'b0;
      uir_armed  <= 1'b0;
      udr_armed  <= 1'b0;
      settle_cnt <= ST_W'(SYNC_STAGES + 1);
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_hist <= uir_sync[SYNC_STAGES-1];
      udr_hist <= udr_sync[SYNC_STAGES-1];
      if (!settle_done) settle_cnt <= settle_cnt - ST_W'(1);
      if (settle_done && !uir_sync[SYNC_STAGES-1]) uir_armed <= 1'b1;
      if (settle_done && !udr_sync[SYNC_STAGES-1]) udr_armed <= 1'b1;
    end
  end

  assign ev_uir = uir_armed & uir_sync[SYNC_STAGES-1] & ~uir_hist;
  assign ev_udr = udr_armed & udr_sync[SYNC_STAGES-1] & ~udr_hist;

  // The push below reads ir_lat before this update, so a simultaneous
  // update-IR/update-DR queues the command under the previous IR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ir_lat <= '0;
    else if (ev_uir) ir_lat <= ir_in;
  end

  assign push_data = '{ir: ir_lat, sr: sr};

  nios2_dbg_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ev_udr),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign pop         = ~fifo_empty & ch_ready[head.ir];
  assign head_onehot = NCH'(1) << head.ir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      if (pop) begin
        jdo <= head.sr;
        if (head.sr[ACT_BIT]) take_action    <= head_onehot;
        else                  take_no_action <= head_onehot;
      end
    end
  end

  // A dropped command sets the flag even if ovf_clr is asserted in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             overflow <= 1'b0;
    else if (ev_udr && fifo_full && !pop)  overflow <= 1'b1;
    else if (ovf_clr)                      overflow <= 1'b0;
  end

endmodule

// File: tb/tb_nios2_dbg_slave_sysclk_mc.sv
module tb_nios2_dbg_slave_sysclk_mc;
  import nios2_dbg_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic [IR_W-1:0] ir_in;
  logic [SR_W-1:0] sr;
  logic            vs_uir, vs_udr, ovf_clr;
  logic [NCH-1:0]  ch_ready;
  logic [SR_W-1:0] jdo;
  logic [NCH-1:0]  take_action, take_no_action;
  logic [2:0]      fifo_level;
  logic            overflow;

  nios2_dbg_slave_sysclk_mc dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .ch_ready(ch_ready), .ovf_clr(ovf_clr), .jdo(jdo), .take_action(take_action),
    .take_no_action(take_no_action), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            act;
    logic [IR_W-1:0] ch;
    logic [SR_W-1:0] sr;
    int              cyc;
    logic            multi;
  } obs_t;

  typedef struct {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] sr;
  } cmd_t;

  obs_t            obs_q[$];
  cmd_t            exp_q[$];
  logic [IR_W-1:0] model_ir;
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  bit              rand_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: every strobe cycle becomes one record with the jdo seen alongside it.
  always @(negedge clk) begin
    obs_t o;
    if (!reset && ((take_action | take_no_action) != '0)) begin
      o.act   = |take_action;
      o.ch    = '0;
      for (int i = 0; i < NCH; i++)
        if (take_action[i] | take_no_action[i]) o.ch = IR_W'(i);
      o.multi = ($countones({take_action, take_no_action}) != 1);
      o.sr    = jdo;
      o.cyc   = cyc;
      obs_q.push_back(o);
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rand_ready)
      for (int i = 0; i < NCH; i++) ch_ready[i] = ($urandom_range(7) != 0);
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [SR_W-1:0] rand_sr();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[SR_W-1:0];
  endfunction

  task automatic pulse_uir(input logic [IR_W-1:0] ir);
    ir_in = ir; vs_uir = 1'b1;
    wait_n(2);
    vs_uir = 1'b0;
    wait_n(2);
    model_ir = ir;
  endtask

  task automatic pulse_udr(input logic [SR_W-1:0] s, output int d);
    sr = s; vs_udr = 1'b1; d = cyc;
    wait_n(2);
    vs_udr = 1'b0;
    wait_n(2);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (take_action !== '0) begin errors++; $display("FAIL rst_take_action got %b exp 0", take_action); end
    checks++; if (take_no_action !== '0) begin errors++; $display("FAIL rst_take_no_action got %b exp 0", take_no_action); end
    checks++; if (jdo !== '0) begin errors++; $display("FAIL rst_jdo got %h exp 0", jdo); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b exp 0", overflow); end
    reset = 1'b0;
    wait_n(8);
  endtask

  task automatic test_single();
    int d;
    logic [SR_W-1:0] s;
    s = 38'h15_0000_00AB;
    ch_ready = '1;
    pulse_uir(2);
    obs_q.delete();
    pulse_udr(s, d);
    wait_n(8);
    checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL t1_count got %0d exp 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      checks++; if (obs_q[0].act !== 1'b1 || obs_q[0].ch !== 2'd2) begin errors++; $display("FAIL t1_strobe got act=%b ch=%0d exp act=1 ch=2", obs_q[0].act, obs_q[0].ch); end
      checks++; if (obs_q[0].cyc !== d + 4) begin errors++; $display("FAIL t1_latency got cyc %0d exp %0d", obs_q[0].cyc, d + 4); end
      checks++; if (obs_q[0].sr !== s) begin errors++; $display("FAIL t1_jdo got %h exp %h", obs_q[0].sr, s); end
    end
    checks++; if (jdo !== s) begin errors++; $display("FAIL t1_jdo_hold got %h exp %h", jdo, s); end
  endtask

  task automatic test_backpressure();
    int d;
    logic [SR_W-1:0] s;
    s = rand_sr();
    s[ACT_BIT] = 1'b0;
    ch_ready = 4'b1101;
    pulse_uir(1);
    obs_q.delete();
    pulse_udr(s, d);
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL t2_level_held got %0d exp 1", fifo_level); end
    wait_n(6);
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL t2_no_strobe got %0d strobes exp 0", obs_q.size()); end
    ch_ready = '1;
    wait_n(5);
    checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL t2_count got %0d exp 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      checks++; if (obs_q[0].act !== 1'b0 || obs_q[0].ch !== 2'd1 || obs_q[0].sr !== s) begin errors++; $display("FAIL t2_strobe got act=%b ch=%0d sr=%h exp act=0 ch=1 sr=%h", obs_q[0].act, obs_q[0].ch, obs_q[0].sr, s); end
    end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL t2_level_drained got %0d exp 0", fifo_level); end
  endtask

  task automatic test_overflow();
    int d;
    logic [SR_W-1:0] s;
    ch_ready = '0;
    pulse_uir(0);
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < 5; i++) begin
      s = rand_sr();
      s[ACT_BIT] = 1'b1;
      if (i < 4) exp_q.push_back('{ir: model_ir, sr: s});
      pulse_udr(s, d);
    end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL t3_level_full got %0d exp 4", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL t3_overflow got %b exp 1", overflow); end
    ch_ready = '1;
    wait_n(8);
    checks++; if (obs_q.size() !== 4) begin errors++; $display("FAIL t3_count got %0d exp 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].sr !== exp_q[i].sr || obs_q[i].ch !== 2'd0 || obs_q[i].act !== 1'b1 || obs_q[i].cyc !== obs_q[0].cyc + i) begin
        errors++;
        $display("FAIL t3_issue%0d got sr=%h ch=%0d act=%b cyc=%0d exp sr=%h ch=0 act=1 cyc=%0d", i, obs_q[i].sr, obs_q[i].ch, obs_q[i].act, obs_q[i].cyc, exp_q[i].sr, obs_q[0].cyc + i);
      end
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t3_ovf_clr got %b exp 0", overflow); end
  endtask

  task automatic test_simultaneous();
    int d;
    logic [SR_W-1:0] s1, s2;
    s1 = rand_sr();
    s2 = rand_sr();
    ch_ready = '1;
    pulse_uir(1);
    obs_q.delete();
    ir_in = 2'd3; sr = s1; vs_uir = 1'b1; vs_udr = 1'b1;
    wait_n(2);
    vs_uir = 1'b0; vs_udr = 1'b0;
    wait_n(2);
    pulse_udr(s2, d);
    wait_n(6);
    checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL t4_count got %0d exp 2", obs_q.size()); end
    if (obs_q.size() >= 2) begin
      checks++; if (obs_q[0].ch !== 2'd1 || obs_q[0].sr !== s1 || obs_q[0].act !== s1[ACT_BIT]) begin errors++; $display("FAIL t4_first got ch=%0d sr=%h exp ch=1 sr=%h", obs_q[0].ch, obs_q[0].sr, s1); end
      checks++; if (obs_q[1].ch !== 2'd3 || obs_q[1].sr !== s2 || obs_q[1].act !== s2[ACT_BIT]) begin errors++; $display("FAIL t4_second got ch=%0d sr=%h exp ch=3 sr=%h", obs_q[1].ch, obs_q[1].sr, s2); end
    end
  endtask

  task automatic test_full_pop();
    int d;
    logic [SR_W-1:0] s5;
    ch_ready = '0;
    pulse_uir(2);
    obs_q.delete();
    for (int i = 0; i < 4; i++) pulse_udr(rand_sr(), d);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL t5_level_full got %0d exp 4", fifo_level); end
    s5 = rand_sr();
    sr = s5; vs_udr = 1'b1;
    tick();
    tick();
    ch_ready = '1;
    tick();
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL t5_level_push_pop got %0d exp 4", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t5_overflow got %b exp 0", overflow); end
    vs_udr = 1'b0;
    wait_n(8);
    checks++; if (obs_q.size() !== 5) begin errors++; $display("FAIL t5_count got %0d exp 5", obs_q.size()); end
    if (obs_q.size() >= 5) begin
      checks++; if (obs_q[4].sr !== s5 || obs_q[4].ch !== 2'd2) begin errors++; $display("FAIL t5_last got sr=%h ch=%0d exp sr=%h ch=2", obs_q[4].sr, obs_q[4].ch, s5); end
    end
  endtask

  task automatic test_reset_mid();
    int d;
    logic [SR_W-1:0] s;
    s = rand_sr();
    ch_ready = '0;
    pulse_uir(0);
    for (int i = 0; i < 3; i++) pulse_udr(rand_sr(), d);
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL t6_level_pre got %0d exp 3", fifo_level); end
    sr = s; vs_udr = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (fifo_level !== '0 || overflow !== 1'b0 || jdo !== '0 || take_action !== '0 || take_no_action !== '0) begin
      errors++;
      $display("FAIL t6_reset_outputs got level=%0d ovf=%b jdo=%h ta=%b tna=%b exp all 0", fifo_level, overflow, jdo, take_action, take_no_action);
    end
    tick();
    reset = 1'b0;
    model_ir = '0;
    ch_ready = '1;
    obs_q.delete();
    wait_n(10);
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL t6_no_refire got %0d strobes exp 0", obs_q.size()); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL t6_level_post got %0d exp 0", fifo_level); end
    vs_udr = 1'b0;
    wait_n(3);
    pulse_udr(s, d);
    wait_n(6);
    checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL t6_rearm_count got %0d exp 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      checks++; if (obs_q[0].ch !== 2'd0 || obs_q[0].sr !== s) begin errors++; $display("FAIL t6_rearm got ch=%0d sr=%h exp ch=0 sr=%h", obs_q[0].ch, obs_q[0].sr, s); end
    end
  endtask

  task automatic test_random();
    int d;
    logic [SR_W-1:0] s;
    exp_q.delete();
    obs_q.delete();
    rand_ready = 1;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(2) == 0) pulse_uir(IR_W'($urandom_range(NCH - 1)));
      s = rand_sr();
      exp_q.push_back('{ir: model_ir, sr: s});
      pulse_udr(s, d);
    end
    rand_ready = 0;
    ch_ready = '1;
    wait_n(12);
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rnd_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].ch !== exp_q[i].ir || obs_q[i].sr !== exp_q[i].sr || obs_q[i].act !== exp_q[i].sr[ACT_BIT] || obs_q[i].multi !== 1'b0) begin
        errors++;
        $display("FAIL rnd_issue%0d got ch=%0d sr=%h act=%b multi=%b exp ch=%0d sr=%h act=%b", i, obs_q[i].ch, obs_q[i].sr, obs_q[i].act, obs_q[i].multi, exp_q[i].ir, exp_q[i].sr, exp_q[i].sr[ACT_BIT]);
      end
    end
    checks++; if (overflow !== 1'b0 || fifo_level !== '0) begin errors++; $display("FAIL rnd_final got ovf=%b level=%0d exp 0 0", overflow, fifo_level); end
  endtask

  initial begin
    reset = 1'b1; ir_in = '0; sr = '0; vs_uir = 1'b0; vs_udr = 1'b0;
    ch_ready = '0; ovf_clr = 1'b0; model_ir = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_simultaneous();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
